l1_tlb: RTL and testbench

Parametrised L1 micro-TLB for the MIPS pipeline. It is the successor of the single-purpose data micro-TLB and serves either the fetch or the memory stage. It holds `NR_ENTRY` fully-associative 4 KiB translations, tagged with ASID and global bit, and refills from the shared L2 TLB over a req/ack handshake. It adds three things the previous block lacked:
- TLB Modified detection on stores
- selective per-VPN2 invalidation
- configurable victim selection

---
 rtl/l1_tlb.sv | 244 ++++++++++++++++++++++++
 tb/tb_l1_tlb.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_tlb.sv
// l1_tlb: fully-associative L1 micro-TLB with L2 refill, TLB Modified detection and fences.
// Define L1TLB_LRU_EN for true-LRU victim selection; otherwise round-robin.
package l1_tlb_pkg;
  typedef struct packed {
    logic [19:0] pfn0;
    logic [19:0] pfn1;
    logic [2:0]  c0;
    logic [2:0]  c1;
    logic        d0;
    logic        d1;
    logic        v0;
    logic        v1;
    logic        g;
  } tlb_entry;
endpackage

module l1_tlb
  import l1_tlb_pkg::*;
#(
  parameter int unsigned NR_ENTRY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [31:0] req_va,
  input  logic        req_write,
  input  logic [7:0]  cur_asid,
  input  logic        ready_go,
  output logic [31:0] pa,
  output logic        uncached,
  output logic        stall,
  output logic        tlb_refill,
  output logic        tlb_invalid,
  output logic        tlb_modified,
  output logic        l2_req,
  output logic [18:0] l2_vpn2,
  input  logic        l2_ack,
  input  logic        l2_found,
  input  tlb_entry    l2_entry,
  input  logic        fence_all,
  input  logic        fence_vpn2_en,
  input  logic [18:0] fence_vpn2
);
  localparam int unsigned IdxW = $clog2(NR_ENTRY);

  typedef struct packed {
    logic [19:0] vpn;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] ppn;
    logic        uncached;
    logic        dirty;
  } l1_entry_t;

  typedef enum logic [1:0] {StIdle, StRefill, StException} state_e;

  state_e               state_q, state_d;
  l1_entry_t            entry_q [NR_ENTRY];
  l1_entry_t            entry_d [NR_ENTRY];
  logic [NR_ENTRY-1:0]  valid_q, valid_d;
  logic [19:0]          vpn_cap_q, vpn_cap_d;
  logic [7:0]           asid_cap_q, asid_cap_d;
  logic                 refill_q, refill_d;
  logic                 invalid_q, invalid_d;

  logic                 mapped, hit, fill, inv_found;
  logic [IdxW-1:0]      hit_idx, inv_idx, policy_idx, victim;

  // Even/odd page of the pair is chosen by the captured va[12].
  logic        odd;
  logic [19:0] sel_pfn;
  logic [2:0]  sel_c;
  logic        sel_d, sel_v;
  assign odd     = vpn_cap_q[0];
  assign sel_pfn = odd ? l2_entry.pfn1 : l2_entry.pfn0;
  assign sel_c   = odd ? l2_entry.c1 : l2_entry.c0;
  assign sel_d   = odd ? l2_entry.d1 : l2_entry.d0;
  assign sel_v   = odd ? l2_entry.v1 : l2_entry.v0;

  assign mapped = (req_va[31:30] != 2'b10);

  // Downward scans so the lowest matching index wins.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int i = int'(NR_ENTRY) - 1; i >= 0; i--) begin
      if (valid_q[i] && entry_q[i].vpn == req_va[31:12] &&
          (entry_q[i].g || entry_q[i].asid == cur_asid)) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
      if (!valid_q[i]) begin
        inv_found = 1'b1;
        inv_idx   = IdxW'(i);
      end
    end
  end

  assign victim = inv_found ? inv_idx : policy_idx;

  always_comb begin
    if (!mapped) begin
      pa       = {3'b000, req_va[28:0]};
      uncached = req_va[29];
    end else begin
      pa       = {entry_q[hit_idx].ppn, req_va[11:0]};
      uncached = entry_q[hit_idx].uncached;
    end
  end

  assign stall        = req_en & ~(((state_q == StIdle) & (~mapped | hit)) |
                                   (state_q == StException));
  assign tlb_modified = req_en & req_write & mapped & hit & ~entry_q[hit_idx].dirty;
  assign tlb_refill   = refill_q;
  assign tlb_invalid  = invalid_q;
  assign l2_req       = (state_q == StRefill);
  assign l2_vpn2      = vpn_cap_q[19:1];

  always_comb begin
    state_d    = state_q;
    vpn_cap_d  = vpn_cap_q;
    asid_cap_d = asid_cap_q;
    refill_d   = refill_q;
    invalid_d  = invalid_q;
    fill       = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_en && mapped && !hit) begin
          state_d    = StRefill;
          vpn_cap_d  = req_va[31:12];
          asid_cap_d = cur_asid;
        end
      end
      StRefill: begin
        if (l2_ack) begin
          if (!l2_found) begin
            refill_d = 1'b1;
            state_d  = StException;
          end else if (sel_v) begin
            fill    = 1'b1;
            state_d = StIdle;
          end else begin
            invalid_d = 1'b1;
            state_d   = StException;
          end
        end
      end
      StException: begin
        if (ready_go) begin
          refill_d  = 1'b0;
          invalid_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Fences act on the post-fill view so a simultaneous fill is invalidated.
  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (fill) begin
      entry_d[victim] = '{vpn: vpn_cap_q, asid: asid_cap_q, g: l2_entry.g, ppn: sel_pfn,
                          uncached: (sel_c == 3'd0), dirty: sel_d};
      valid_d[victim] = 1'b1;
    end
    if (ready_go) begin
      for (int i = 0; i < int'(NR_ENTRY); i++) begin
        if (fence_all || (fence_vpn2_en && entry_d[i].vpn[19:1] == fence_vpn2)) begin
          valid_d[i] = 1'b0;
        end
      end
    end
  end

`ifdef L1TLB_LRU_EN
  logic [IdxW-1:0] age_q [NR_ENTRY];
  logic [IdxW-1:0] age_d [NR_ENTRY];
  logic            touch;
  logic [IdxW-1:0] touch_idx, touch_age;

  always_comb begin
    policy_idx = '0;
    for (int i = 0; i < int'(NR_ENTRY); i++) begin
      if (age_q[i] == IdxW'(NR_ENTRY - 1)) policy_idx = IdxW'(i);
    end
  end

  always_comb begin
    touch     = fill | (req_en & mapped & hit & ready_go);
    touch_idx = fill ? victim : hit_idx;
    touch_age = age_q[touch_idx];
    age_d     = age_q;
    if (touch) begin
      for (int i = 0; i < int'(NR_ENTRY); i++) begin
        if (IdxW'(i) == touch_idx) age_d[i] = '0;
        else if (age_q[i] < touch_age) age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NR_ENTRY); i++) age_q[i] <= IdxW'(i);
    end else begin
      age_q <= age_d;
    end
  end
`else
  logic [IdxW-1:0] rr_q, rr_d;

  assign policy_idx = rr_q;
  assign rr_d       = (fill && !inv_found) ? rr_q + 1'b1 : rr_q;

  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      entry_q    <= '{default: '0};
      valid_q    <= '0;
      vpn_cap_q  <= '0;
      asid_cap_q <= '0;
      refill_q   <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      valid_q    <= valid_d;
      vpn_cap_q  <= vpn_cap_d;
      asid_cap_q <= asid_cap_d;
      refill_q   <= refill_d;
      invalid_q  <= invalid_d;
    end
  end

endmodule

// File: tb/tb_l1_tlb.sv
// tb_l1_tlb: directed scoreboard bench for l1_tlb (NR_ENTRY=4); honours L1TLB_LRU_EN.
module tb_l1_tlb;
  import l1_tlb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_en, req_write, ready_go;
  logic [31:0] req_va;
  logic [7:0]  cur_asid;
  logic [31:0] pa;
  logic        uncached, stall, tlb_refill, tlb_invalid, tlb_modified, l2_req;
  logic [18:0] l2_vpn2;
  logic        l2_ack, l2_found;
  tlb_entry    l2_entry;
  logic        fence_all, fence_vpn2_en;
  logic [18:0] fence_vpn2;

  l1_tlb #(.NR_ENTRY(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_en       (req_en),
    .req_va       (req_va),
    .req_write    (req_write),
    .cur_asid     (cur_asid),
    .ready_go     (ready_go),
    .pa           (pa),
    .uncached     (uncached),
    .stall        (stall),
    .tlb_refill   (tlb_refill),
    .tlb_invalid  (tlb_invalid),
    .tlb_modified (tlb_modified),
    .l2_req       (l2_req),
    .l2_vpn2      (l2_vpn2),
    .l2_ack       (l2_ack),
    .l2_found     (l2_found),
    .l2_entry     (l2_entry),
    .fence_all    (fence_all),
    .fence_vpn2_en(fence_vpn2_en),
    .fence_vpn2   (fence_vpn2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] VaA = 32'h0100_0000;
  localparam logic [31:0] VaB = 32'h0100_2000;
  localparam logic [31:0] VaC = 32'h0100_4000;
  localparam logic [31:0] VaD = 32'h0100_6000;
  localparam logic [31:0] VaE = 32'h0100_8000;
  localparam logic [31:0] VaF = 32'h0100_A000;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow observed %h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  function automatic tlb_entry mk(input logic odd, input logic [19:0] pfn, input logic [2:0] c,
                                  input logic d, input logic v, input logic g);
    tlb_entry e;
    e   = '0;
    e.g = g;
    if (odd) begin
      e.pfn1 = pfn; e.c1 = c; e.d1 = d; e.v1 = v;
    end else begin
      e.pfn0 = pfn; e.c0 = c; e.d0 = d; e.v0 = v;
    end
    return e;
  endfunction

  // Drives a miss on va from IDLE, acks after `delay` cycles of l2_req; returns in cycle N+1.
  task automatic refill(input string tag, input logic [31:0] va, input tlb_entry e,
                        input logic found, input int delay, input logic fence);
    int n;
    req_en = 1'b1;
    req_va = va;
    expect_val(tag, 32'd1);
    samp();
    compare({31'd0, stall});
    tick();
    n = 0;
    while (!l2_req && n < 8) begin
      tick();
      n++;
    end
    expect_val("l2_req_rise", 32'd1);
    compare({31'd0, l2_req});
    expect_val("l2_vpn2", {13'd0, va[31:13]});
    compare({13'd0, l2_vpn2});
    repeat (delay) tick();
    l2_ack   = 1'b1;
    l2_found = found;
    l2_entry = e;
    if (fence) begin
      fence_all = 1'b1;
      ready_go  = 1'b1;
    end
    tick();
    l2_ack    = 1'b0;
    l2_found  = 1'b0;
    l2_entry  = '0;
    fence_all = 1'b0;
    ready_go  = 1'b0;
    expect_val("l2_req_drop", 32'd0);
    compare({31'd0, l2_req});
  endtask

  task automatic clear_exc();
    req_en   = 1'b0;
    ready_go = 1'b1;
    tick();
    ready_go = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ev_va, kept_va;
    logic [19:0] kept_pfn;
    rst = 1'b1; req_en = 1'b0; req_write = 1'b0; ready_go = 1'b0;
    req_va = '0; cur_asid = '0; l2_ack = 1'b0; l2_found = 1'b0; l2_entry = '0;
    fence_all = 1'b0; fence_vpn2_en = 1'b0; fence_vpn2 = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    expect_val("rst_refill", 32'd0);
    expect_val("rst_invalid", 32'd0);
    expect_val("rst_l2_req", 32'd0);
    expect_val("rst_l2_vpn2", 32'd0);
    samp();
    compare({31'd0, tlb_refill});
    compare({31'd0, tlb_invalid});
    compare({31'd0, l2_req});
    compare({13'd0, l2_vpn2});

    // Unmapped bypass
    tick();
    req_en = 1'b1; req_va = 32'hA000_1234;
    expect_val("unm_pa", 32'h0000_1234);
    expect_val("unm_uncached", 32'd1);
    expect_val("unm_stall", 32'd0);
    expect_val("unm_l2_req", 32'd0);
    samp();
    compare(pa); compare({31'd0, uncached}); compare({31'd0, stall}); compare({31'd0, l2_req});
    tick();
    expect_val("unm_l2_req_hold", 32'd0);
    samp();
    compare({31'd0, l2_req});

    // Miss and refill, odd page
    tick();
    cur_asid = 8'd5;
    refill("miss_stall", 32'h0040_3010, mk(1'b1, 20'h01F00, 3'd3, 1'b1, 1'b1, 1'b0), 1'b1, 3,
           1'b0);
    expect_val("fill_stall", 32'd0);
    expect_val("fill_pa", 32'h01F0_0010);
    expect_val("fill_uncached", 32'd0);
    samp();
    compare({31'd0, stall}); compare(pa); compare({31'd0, uncached});
    tick();
    req_en = 1'b0;
    tick();
    req_en = 1'b1;
    expect_val("rehit_stall", 32'd0);
    expect_val("rehit_pa", 32'h01F0_0010);
    samp();
    compare({31'd0, stall}); compare(pa);

    // ASID mismatch misses; global refill hits under any ASID
    tick();
    cur_asid = 8'd6;
    refill("asid_miss", 32'h0040_3010, mk(1'b1, 20'h00ABC, 3'd3, 1'b1, 1'b1, 1'b1), 1'b1, 1,
           1'b0);
    expect_val("glob_pa6", 32'h00AB_C010);
    samp();
    compare(pa);
    tick();
    cur_asid = 8'd5;
    expect_val("lowest_idx_pa", 32'h01F0_0010);
    samp();
    compare(pa);
    tick();
    cur_asid = 8'd9;
    expect_val("glob_stall9", 32'd0);
    expect_val("glob_pa9", 32'h00AB_C010);
    samp();
    compare({31'd0, stall}); compare(pa);

    // L2 miss -> tlb_refill, held until ready_go inclusive
    tick();
    refill("exc_miss", 32'h0050_0000, '0, 1'b0, 0, 1'b0);
    expect_val("refill_flag", 32'd1);
    expect_val("refill_no_inv", 32'd0);
    expect_val("refill_stall", 32'd0);
    samp();
    compare({31'd0, tlb_refill}); compare({31'd0, tlb_invalid}); compare({31'd0, stall});
    tick();
    expect_val("refill_hold", 32'd1);
    samp();
    compare({31'd0, tlb_refill});
    tick();
    req_en = 1'b0; ready_go = 1'b1;
    expect_val("refill_rg_cycle", 32'd1);
    samp();
    compare({31'd0, tlb_refill});
    tick();
    ready_go = 1'b0;
    expect_val("refill_cleared", 32'd0);
    samp();
    compare({31'd0, tlb_refill});

    // V=0 -> tlb_invalid
    tick();
    refill("inv_miss", 32'h0050_0000, mk(1'b0, 20'h11111, 3'd3, 1'b1, 1'b0, 1'b0), 1'b1, 2,
           1'b0);
    expect_val("invalid_flag", 32'd1);
    expect_val("invalid_no_refill", 32'd0);
    samp();
    compare({31'd0, tlb_invalid}); compare({31'd0, tlb_refill});
    tick();
    clear_exc();
    expect_val("invalid_cleared", 32'd0);
    samp();
    compare({31'd0, tlb_invalid});

    // Store to D=0 entry, C=0 -> uncached
    tick();
    refill("st_miss", 32'h0060_0000, mk(1'b0, 20'h12345, 3'd0, 1'b0, 1'b1, 1'b0), 1'b1, 1,
           1'b0);
    req_write = 1'b1;
    expect_val("mod_flag", 32'd1);
    expect_val("mod_stall", 32'd0);
    expect_val("mod_pa", 32'h1234_5000);
    expect_val("mod_uncached", 32'd1);
    samp();
    compare({31'd0, tlb_modified}); compare({31'd0, stall}); compare(pa);
    compare({31'd0, uncached});
    tick();
    req_write = 1'b0;
    expect_val("mod_load", 32'd0);
    samp();
    compare({31'd0, tlb_modified});
    tick();
    req_write = 1'b1; req_va = 32'h0040_3010;
    expect_val("mod_dirty_entry", 32'd0);
    samp();
    compare({31'd0, tlb_modified});
    tick();
    req_write = 1'b0;

    // fence_all empties the TLB
    req_en = 1'b0; fence_all = 1'b1; ready_go = 1'b1;
    tick();
    fence_all = 1'b0; ready_go = 1'b0;
    refill("fence_all_miss", 32'h0040_3010, '0, 1'b0, 0, 1'b0);
    clear_exc();

    // Replacement: fill A..D, touch A, miss E
    refill("fill_a", VaA, mk(1'b0, 20'h000A0, 3'd3, 1'b1, 1'b1, 1'b1), 1'b1, 0, 1'b0);
    refill("fill_b", VaB, mk(1'b0, 20'h000B0, 3'd3, 1'b1, 1'b1, 1'b1), 1'b1, 0, 1'b0);
    refill("fill_c", VaC, mk(1'b0, 20'h000C0, 3'd3, 1'b1, 1'b1, 1'b1), 1'b1, 0, 1'b0);
    refill("fill_d", VaD, mk(1'b0, 20'h000D0, 3'd3, 1'b1, 1'b1, 1'b1), 1'b1, 0, 1'b0);
    req_va = VaA; ready_go = 1'b1;
    expect_val("hit_a_pa", 32'h000A_0000);
    samp();
    compare(pa);
    tick();
    ready_go = 1'b0;
    refill("fill_e", VaE, mk(1'b0, 20'h000E0, 3'd3, 1'b1, 1'b1, 1'b1), 1'b1, 0, 1'b0);
    expect_val("hit_e_pa", 32'h000E_0000);
    samp();
    compare(pa);
`ifdef L1TLB_LRU_EN
    ev_va = VaB; kept_va = VaA; kept_pfn = 20'h000A0;
`else
    ev_va = VaA; kept_va = VaB; kept_pfn = 20'h000B0;
`endif
    tick();
    req_va = kept_va;
    expect_val("kept_stall", 32'd0);
    expect_val("kept_pa", {kept_pfn, 12'h000});
    samp();
    compare({31'd0, stall}); compare(pa);
    tick();
    refill("evicted_miss", ev_va, '0, 1'b0, 0, 1'b0);
    clear_exc();

    // Selective fence on C
    req_en = 1'b0; fence_vpn2_en = 1'b1; fence_vpn2 = VaC[31:13]; ready_go = 1'b1;
    tick();
    fence_vpn2_en = 1'b0; ready_go = 1'b0;
    req_en = 1'b1; req_va = VaD;
    expect_val("fv_d_stall", 32'd0);
    expect_val("fv_d_pa", 32'h000D_0000);
    samp();
    compare({31'd0, stall}); compare(pa);
    tick();
    req_va = kept_va;
    expect_val("fv_kept_stall", 32'd0);
    samp();
    compare({31'd0, stall});
    tick();
    refill("fv_c_miss", VaC, '0, 1'b0, 0, 1'b0);
    clear_exc();

    // fence_all coincident with a refill ack: victim ends invalid too
    refill("fa_ack_miss", VaF, mk(1'b0, 20'h000F0, 3'd3, 1'b1, 1'b1, 1'b1), 1'b1, 1, 1'b1);
    refill("fa_victim_miss", VaF, '0, 1'b0, 0, 1'b0);
    clear_exc();
    refill("fa_d_miss", VaD, '0, 1'b0, 0, 1'b0);
    clear_exc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
